eq_seq_ctrl: RTL and testbench

- Sequencer that compares two W-bit words for equality using one shared 2-bit equality slice (eq2, itself built from eq1 cells).
- Processes one bit-pair per clock, LSB pair first; start/ready/done handshake.
- Reports the equality result and the index of the first mismatching pair.
- Sits between a requesting core and the comparator datapath; trades latency for one slice instead of W/2.

---
 rtl/eq_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_eq_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eq_seq_ctrl.sv
// -----------------------------------------------------------------------------
// eq_seq_ctrl: bit-serial (pair-serial) equality sequencer.
//
// Compares two W-bit words for equality, one bit-pair per clock, LSB pair
// first. Only one shared 2-bit equality slice (eq2, built from two eq1 cells)
// is used, so the cost is latency instead of W/2 parallel slices.
//
// Optional feature (compile-time macro EQ_SEQ_EARLY_EXIT_EN):
//   defined   - the first mismatching pair ends the scan on that same edge.
//   undefined - all NP pairs are always scanned (constant latency NP+1).
//   aeqb and mm_idx are identical in both builds; only timing differs.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high reset
//   start  in   request, accepted only while ready=1
//   a, b   in   W-bit operands, sampled on the accepting edge only
//   ready  out  high only in IDLE
//   busy   out  high in RUN
//   done   out  one-cycle pulse when aeqb/mm_idx are valid
//   aeqb   out  1 = words equal (held until the next accepted start)
//   mm_idx out  index of the lowest mismatching pair, 0 when aeqb=1
// -----------------------------------------------------------------------------

// Single-bit equality cell.
module eq1 (
   input  logic x,
   input  logic y,
   output logic eq
);
   assign eq = ~(x ^ y);
endmodule

// Two-bit equality slice built from two eq1 cells.
module eq2 (
   input  logic [1:0] x,
   input  logic [1:0] y,
   output logic       eq
);
   logic e0;
   logic e1;

   eq1 u_bit0 (.x(x[0]), .y(y[0]), .eq(e0));
   eq1 u_bit1 (.x(x[1]), .y(y[1]), .eq(e1));

   assign eq = e0 & e1;
endmodule

module eq_seq_ctrl #(
   parameter  int W  = 16,
   localparam int NP = W / 2,
   localparam int IW = (NP > 1) ? $clog2(NP) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   output logic          ready,
   output logic          busy,
   output logic          done,
   output logic          aeqb,
   output logic [IW-1:0] mm_idx
);

   if ((W < 2) || ((W % 2) != 0)) begin : g_bad_width
      $error("eq_seq_ctrl: W must be even and >= 2");
   end

   localparam logic [IW-1:0] LAST = IW'(NP - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state;
   logic [W-1:0]  sa;
   logic [W-1:0]  sb;
   logic [IW-1:0] cnt;
   logic          acc;
   logic          first;
   logic [IW-1:0] mm_r;

   logic          e;
   logic          stop_early;
   logic          last_pair;
   logic [IW-1:0] mm_next;

   // The one shared slice always looks at the current lowest pair.
   eq2 u_eq2 (.x(sa[1:0]), .y(sb[1:0]), .eq(e));

`ifdef EQ_SEQ_EARLY_EXIT_EN
   assign stop_early = ~e;
`else
   assign stop_early = 1'b0;
`endif

   assign last_pair = (cnt == LAST);
   // The final edge may itself be the first mismatch, so fold it in here.
   assign mm_next   = (!e && first) ? cnt : mm_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         ready  <= 1'b1;
         busy   <= 1'b0;
         done   <= 1'b0;
         aeqb   <= 1'b0;
         mm_idx <= '0;
         sa     <= '0;
         sb     <= '0;
         cnt    <= '0;
         acc    <= 1'b0;
         first  <= 1'b0;
         mm_r   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  sa     <= a;
                  sb     <= b;
                  cnt    <= '0;
                  acc    <= 1'b1;
                  first  <= 1'b1;
                  mm_r   <= '0;
                  aeqb   <= 1'b0;
                  mm_idx <= '0;
                  ready  <= 1'b0;
                  busy   <= 1'b1;
                  state  <= S_RUN;
               end
            end

            S_RUN: begin
               acc <= acc & e;
               sa  <= sa >> 2;
               sb  <= sb >> 2;
               cnt <= cnt + IW'(1);
               if (!e && first) begin
                  mm_r  <= cnt;
                  first <= 1'b0;
               end
               if (last_pair || stop_early) begin
                  aeqb   <= acc & e;
                  mm_idx <= mm_next;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= S_DONE;
               end
            end

            S_DONE: begin
               ready <= 1'b1;
               state <= S_IDLE;
            end

            default: begin
               ready <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eq_seq_ctrl.sv
module tb_eq_seq_ctrl;

   localparam int W  = 16;
   localparam int NP = W / 2;
   localparam int IW = 3;

`ifdef EQ_SEQ_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic          clk;
   logic          reset;
   logic          start;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          ready;
   logic          busy;
   logic          done;
   logic          aeqb;
   logic [IW-1:0] mm_idx;

   int n_cmp = 0;
   int n_bad = 0;

   eq_seq_ctrl #(.W(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .a      (a),
      .b      (b),
      .ready  (ready),
      .busy   (busy),
      .done   (done),
      .aeqb   (aeqb),
      .mm_idx (mm_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         eq;
      int           idx;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled at the negedge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Reference: equality, lowest differing pair, and cycles from accepting
   // edge to the done cycle.
   function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic eq, output int idx, output int lat);
      eq  = (x == y);
      idx = 0;
      for (int i = NP - 1; i >= 0; i--)
         if (x[2*i +: 2] != y[2*i +: 2]) idx = i;
      lat = (EARLY && !eq) ? idx + 2 : NP + 1;
   endfunction

   // Called in the cycle right after the accepting edge; returns the cycle
   // offset (1 = first cycle after accept) at which done is seen.
   task automatic wait_done(input string tag, output int lat);
      chk({tag, ".ready_low"}, int'(ready), 0);
      chk({tag, ".busy_high"}, int'(busy), 1);
      lat = 1;
      while (!done && lat < NP + 6) begin
         tick();
         lat++;
      end
   endtask

   task automatic run_check(input string tag, input logic [W-1:0] ta,
                            input logic [W-1:0] tb_v);
      logic eq_e;
      int   idx_e;
      int   lat_e;
      int   lat;
      model(ta, tb_v, eq_e, idx_e, lat_e);
      a = ta;
      b = tb_v;
      start = 1'b1;
      tick();
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      wait_done(tag, lat);
      chk({tag, ".latency"}, lat, lat_e);
      chk({tag, ".aeqb"}, int'(aeqb), int'(eq_e));
      chk({tag, ".mm_idx"}, int'(mm_idx), idx_e);
      tick();
      chk({tag, ".done_one_cycle"}, int'(done), 0);
      chk({tag, ".ready_back"}, int'(ready), 1);
   endtask

   initial begin
      int lat;
      int ndone;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      vecs[0] = '{16'hA5C3, 16'hA5C3, 1'b1, 0};
      vecs[1] = '{16'h0001, 16'h0000, 1'b0, 0};
      vecs[2] = '{16'h8000, 16'h0000, 1'b0, 7};
      vecs[3] = '{16'h0C00, 16'h0000, 1'b0, 5};
      vecs[4] = '{16'hFFFF, 16'hFFFE, 1'b0, 0};
      vecs[5] = '{16'h0000, 16'h0000, 1'b1, 0};
      vecs[6] = '{16'h0030, 16'h0000, 1'b0, 2};
      vecs[7] = '{16'h1234, 16'h1634, 1'b0, 5};

      reset = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      @(negedge clk);
      tick();
      chk("rst.ready", int'(ready), 1);
      chk("rst.busy", int'(busy), 0);
      chk("rst.done", int'(done), 0);
      chk("rst.aeqb", int'(aeqb), 0);
      chk("rst.mm_idx", int'(mm_idx), 0);
      reset = 1'b0;
      tick();

      // Directed table.
      foreach (vecs[i]) begin
         int lat_e;
         a = vecs[i].a;
         b = vecs[i].b;
         start = 1'b1;
         tick();
         start = 1'b0;
         a = '0;
         b = '1;
         lat_e = (EARLY && !vecs[i].eq) ? vecs[i].idx + 2 : NP + 1;
         wait_done($sformatf("vec%0d", i), lat);
         chk($sformatf("vec%0d.latency", i), lat, lat_e);
         chk($sformatf("vec%0d.aeqb", i), int'(aeqb), int'(vecs[i].eq));
         chk($sformatf("vec%0d.mm_idx", i), int'(mm_idx), vecs[i].idx);
         tick();
         chk($sformatf("vec%0d.done_pulse", i), int'(done), 0);
         chk($sformatf("vec%0d.hold_aeqb", i), int'(aeqb), int'(vecs[i].eq));
      end

      // Starts during RUN (k+3) and DONE (k+9) must be ignored.
      a = 16'h1234;
      b = 16'h1234;
      start = 1'b1;
      tick();
      start = 1'b0;
      ndone = 0;
      for (int c = 1; c <= 14; c++) begin
         if (done) begin
            ndone++;
            chk("ign.done_cycle", c, NP + 1);
            chk("ign.aeqb", int'(aeqb), 1);
         end
         if (c == 3 || c == 9) begin
            a = 16'hFFFF;
            b = 16'h0000;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      chk("ign.done_count", ndone, 1);
      chk("ign.ready", int'(ready), 1);
      chk("ign.aeqb_hold", int'(aeqb), 1);

      // Reset at k+4 aborts the run with no done pulse.
      a = 16'h8000;
      b = 16'h0000;
      start = 1'b1;
      tick();
      start = 1'b0;
      ndone = 0;
      for (int c = 1; c <= 14; c++) begin
         if (done) ndone++;
         if (c == 5) begin
            chk("rstmid.ready", int'(ready), 1);
            chk("rstmid.busy", int'(busy), 0);
            chk("rstmid.aeqb", int'(aeqb), 0);
            chk("rstmid.mm_idx", int'(mm_idx), 0);
         end
         reset = (c == 4);
         tick();
      end
      chk("rstmid.no_done", ndone, 0);
      run_check("rstmid.fresh", 16'h0C00, 16'h0000);

      // Back-to-back: equal op, then a new start in the cycle after done.
      a = 16'hA5C3;
      b = 16'hA5C3;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("b2b.first", lat);
      chk("b2b.first.latency", lat, NP + 1);
      chk("b2b.first.aeqb", int'(aeqb), 1);
      a = 16'hFFFF;
      b = 16'hFFFE;
      start = 1'b1;
      tick();
      chk("b2b.ready_k10", int'(ready), 1);
      tick();
      start = 1'b0;
      chk("b2b.clear_aeqb", int'(aeqb), 0);
      chk("b2b.clear_mm", int'(mm_idx), 0);
      wait_done("b2b.second", lat);
      chk("b2b.second.latency", lat, EARLY ? 2 : NP + 1);
      chk("b2b.second.aeqb", int'(aeqb), 0);
      chk("b2b.second.mm_idx", int'(mm_idx), 0);
      tick();

      // Randomized operations against the reference model.
      for (int n = 0; n < 60; n++) begin
         ra = W'($urandom);
         case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
            2:       rb = W'($urandom);
            default: rb = ra ^ (W'(1) << $urandom_range(0, W - 1))
                            ^ (W'(1) << $urandom_range(0, W - 1));
         endcase
         run_check($sformatf("rnd%0d", n), ra, rb);
         if ($urandom_range(0, 1) == 1) tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
